kl8e_iot_ctrl: RTL and testbench



---
 rtl/kl8e_iot_ctrl.sv | 149 ++++++++++++++
 tb/tb_kl8e_iot_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/kl8e_iot_ctrl.sv
// kl8e_iot_ctrl: console keyboard/teleprinter IOT decode, flags, receive buffer and transmit hand-off
module kl8e_iot_ctrl #(
    parameter logic [3:0] F0      = 4'd0,
    parameter logic [3:0] F1      = 4'd1,
    parameter logic [3:0] F2      = 4'd2,
    parameter logic [3:0] F3      = 4'd3,
    parameter logic [5:0] KBD_DEV = 6'o03,
    parameter logic [5:0] TTY_DEV = 6'o04
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:11] instruction,
    input  logic [3:0]  state,
    input  logic [0:11] ac,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_busy,
    input  logic        tx_done,
    output logic        tx_load,
    output logic [7:0]  tx_data,
    output logic [0:11] serial_bus,
    output logic        clear_ac,
    output logic        skip,
    output logic        interrupt,
    output logic        overrun
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [5:0] dev;
    logic [2:0] fn;
    logic       iot_op, kbd_iot, tty_iot;
    logic       kcf, ksf, kcc, krs, kie, krb;
    logic       spf, tsf, tcf, tpc, tsk, tls;
    logic       xmit;
    logic [7:0] xbyte;
    logic       kbd_flag, tty_flag, ie, pend;
    logic [7:0] rx_buf, pend_byte;
    logic [1:0] seq;
    logic       nxt_skip, nxt_clear;
    logic [0:11] nxt_bus;
    logic       unused_ok;

    assign dev     = instruction[3:8];
    assign fn      = instruction[9:11];
    assign iot_op  = (state == F1) && (instruction[0:2] == 3'o6);
    assign kbd_iot = iot_op && (dev == KBD_DEV);
    assign tty_iot = iot_op && (dev == TTY_DEV);

    assign kcf = kbd_iot && (fn == 3'd0);
    assign ksf = kbd_iot && (fn == 3'd1);
    assign kcc = kbd_iot && (fn == 3'd2);
    assign krs = kbd_iot && (fn == 3'd4);
    assign kie = kbd_iot && (fn == 3'd5);
    assign krb = kbd_iot && (fn == 3'd6);
    assign spf = tty_iot && (fn == 3'd0);
    assign tsf = tty_iot && (fn == 3'd1);
    assign tcf = tty_iot && (fn == 3'd2);
    assign tpc = tty_iot && (fn == 3'd4);
    assign tsk = tty_iot && (fn == 3'd5);
    assign tls = tty_iot && (fn == 3'd6);

    assign xmit  = tpc | tls;
    assign xbyte = ac[4:11];

    // Skip tests use the flag values present before this edge's updates.
    assign nxt_skip  = (ksf & kbd_flag) | (tsf & tty_flag) | (tsk & (tty_flag | kbd_flag));
    assign nxt_clear = kcc | krb;
    assign nxt_bus   = (krs | krb) ? {4'b0, rx_buf} : 12'b0;

    // High accumulator bits and the F2/F3 codes have no role in this device.
    assign unused_ok = ^{ac[0:3], F2, F3};

    // CPU-facing results latch on the IOT clock and drop when the next F0 begins.
    always_ff @(posedge clk) begin
        if (reset) begin
            skip       <= 1'b0;
            clear_ac   <= 1'b0;
            serial_bus <= 12'b0;
        end else if (kbd_iot | tty_iot) begin
            skip       <= nxt_skip;
            clear_ac   <= nxt_clear;
            serial_bus <= nxt_bus;
        end else if (state == F0) begin
            skip       <= 1'b0;
            clear_ac   <= 1'b0;
            serial_bus <= 12'b0;
        end
    end

    // Device flags, interrupt enable and receive status; hardware sets win over IOT clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            kbd_flag  <= 1'b0;
            tty_flag  <= 1'b0;
            ie        <= 1'b1;
            overrun   <= 1'b0;
            rx_buf    <= 8'h00;
            interrupt <= 1'b0;
        end else begin
            kbd_flag  <= rx_valid | (kbd_flag & ~(kcf | kcc | krb));
            tty_flag  <= tx_done | spf | (tty_flag & ~(tcf | tls));
            ie        <= kie ? ac[11] : ie;
            overrun   <= (rx_valid & kbd_flag) | (overrun & ~(kcc | krb));
            rx_buf    <= rx_valid ? rx_data : rx_buf;
            interrupt <= ie & (kbd_flag | tty_flag);
        end
    end

    // Transmit hand-off: load directly when the UART is free, otherwise park one byte (last wins).
    always_ff @(posedge clk) begin
        if (reset) begin
            seq       <= IDLE;
            pend      <= 1'b0;
            pend_byte <= 8'h00;
            tx_load   <= 1'b0;
            tx_data   <= 8'h00;
        end else begin
            tx_load <= 1'b0;
            if (seq == IDLE) begin
                if (xmit && !tx_busy) begin
                    tx_data <= xbyte;
                    tx_load <= 1'b1;
                    seq     <= SEND;
                end else if (xmit) begin
                    pend_byte <= xbyte;
                    pend      <= 1'b1;
                    seq       <= WAIT;
                end
            end else if (seq == SEND) begin
                seq <= xmit ? WAIT : IDLE;
                if (xmit) begin
                    pend_byte <= xbyte;
                    pend      <= 1'b1;
                end
            end else begin
                if (xmit)
                    pend_byte <= xbyte;
                if (pend && !tx_busy) begin
                    tx_data <= xmit ? xbyte : pend_byte;
                    tx_load <= 1'b1;
                    pend    <= 1'b0;
                    seq     <= SEND;
                end
            end
        end
    end
endmodule

// File: tb/tb_kl8e_iot_ctrl.sv
// tb_kl8e_iot_ctrl: directed vector table plus transmit/reset corner sequences for kl8e_iot_ctrl
module tb_kl8e_iot_ctrl;
    localparam logic [3:0] F0 = 4'd0;
    localparam logic [3:0] F1 = 4'd1;
    localparam logic [3:0] F2 = 4'd2;
    localparam logic [3:0] F3 = 4'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [0:11] instruction = 12'o7000;
    logic [3:0]  state = 4'd0;
    logic [0:11] ac = 12'o0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_busy = 1'b0;
    logic        tx_done = 1'b0;
    logic        tx_load;
    logic [7:0]  tx_data;
    logic [0:11] serial_bus;
    logic        clear_ac, skip, interrupt, overrun;

    int checks = 0;
    int errors = 0;

    kl8e_iot_ctrl dut (
        .clk(clk), .reset(reset), .instruction(instruction), .state(state), .ac(ac),
        .rx_valid(rx_valid), .rx_data(rx_data), .tx_busy(tx_busy), .tx_done(tx_done),
        .tx_load(tx_load), .tx_data(tx_data), .serial_bus(serial_bus), .clear_ac(clear_ac),
        .skip(skip), .interrupt(interrupt), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [11:0] ins;
        logic [3:0]  st;
        logic [11:0] acv;
        logic        rxv;
        logic [7:0]  rxd;
        logic        busy;
        logic        done;
        logic [24:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [24:0] e(logic ld, logic [7:0] txd, logic [11:0] sb,
                                      logic ca, logic sk, logic irq, logic ov);
        return {ld, txd, sb, ca, sk, irq, ov};
    endfunction

    function automatic vec_t r(string n, logic rst, logic [11:0] ins, logic [3:0] st,
                               logic [11:0] acv, logic rxv, logic [7:0] rxd,
                               logic busy, logic done, logic [24:0] x);
        vec_t v;
        v.name = n; v.rst = rst; v.ins = ins; v.st = st; v.acv = acv;
        v.rxv = rxv; v.rxd = rxd; v.busy = busy; v.done = done; v.exp = x;
        return v;
    endfunction

    function automatic logic [24:0] outs();
        return {tx_load, tx_data, serial_bus, clear_ac, skip, interrupt, overrun};
    endfunction

    task automatic drive(input vec_t v);
        @(negedge clk);
        reset = v.rst; instruction = v.ins; state = v.st; ac = v.acv;
        rx_valid = v.rxv; rx_data = v.rxd; tx_busy = v.busy; tx_done = v.done;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string n, input logic [24:0] got, input logic [24:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", n, got, want);
        end
    endtask

    task automatic hs(input logic rst, input logic [11:0] ins, input logic [3:0] st,
                      input logic [11:0] acv, input logic busy);
        drive(r("h", rst, ins, st, acv, 1'b0, 8'h00, busy, 1'b0, 25'd0));
    endtask

    initial begin
        int n, cnt;
        logic got;
        tbl.push_back(r("rst",        1, 12'o7000, F0, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'h00, 12'o0000, 0, 0, 0, 0)));
        tbl.push_back(r("nop_f0",     0, 12'o7000, F0, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'h00, 12'o0000, 0, 0, 0, 0)));
        tbl.push_back(r("nop_f1",     0, 12'o7000, F1, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'h00, 12'o0000, 0, 0, 0, 0)));
        tbl.push_back(r("nop_f2",     0, 12'o7000, F2, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'h00, 12'o0000, 0, 0, 0, 0)));
        tbl.push_back(r("nop_f3",     0, 12'o7000, F3, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'h00, 12'o0000, 0, 0, 0, 0)));
        tbl.push_back(r("spf_f1",     0, 12'o6040, F1, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'h00, 12'o0000, 0, 0, 0, 0)));
        tbl.push_back(r("spf_f2",     0, 12'o6040, F2, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'h00, 12'o0000, 0, 0, 1, 0)));
        tbl.push_back(r("kie1_f1",    0, 12'o6035, F1, 12'o0001, 0, 8'h00, 0, 0, e(0, 8'h00, 12'o0000, 0, 0, 1, 0)));
        tbl.push_back(r("kie0_f1",    0, 12'o6035, F1, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'h00, 12'o0000, 0, 0, 1, 0)));
        tbl.push_back(r("kie0_f2",    0, 12'o6035, F2, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'h00, 12'o0000, 0, 0, 0, 0)));
        tbl.push_back(r("tsf_f1",     0, 12'o6041, F1, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'h00, 12'o0000, 0, 1, 0, 0)));
        tbl.push_back(r("tsf_f2",     0, 12'o6041, F2, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'h00, 12'o0000, 0, 1, 0, 0)));
        tbl.push_back(r("tsf_f3",     0, 12'o6041, F3, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'h00, 12'o0000, 0, 1, 0, 0)));
        tbl.push_back(r("tsf_f0",     0, 12'o7000, F0, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'h00, 12'o0000, 0, 0, 0, 0)));
        tbl.push_back(r("kie1b_f1",   0, 12'o6035, F1, 12'o0001, 0, 8'h00, 0, 0, e(0, 8'h00, 12'o0000, 0, 0, 0, 0)));
        tbl.push_back(r("kie1b_f2",   0, 12'o6035, F2, 12'o0001, 0, 8'h00, 0, 0, e(0, 8'h00, 12'o0000, 0, 0, 1, 0)));
        tbl.push_back(r("tls_f1",     0, 12'o6046, F1, 12'o0252, 0, 8'h00, 0, 0, e(1, 8'hAA, 12'o0000, 0, 0, 1, 0)));
        tbl.push_back(r("tls_f2",     0, 12'o6046, F2, 12'o0252, 0, 8'h00, 0, 0, e(0, 8'hAA, 12'o0000, 0, 0, 0, 0)));
        tbl.push_back(r("tls_f0",     0, 12'o7000, F0, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'hAA, 12'o0000, 0, 0, 0, 0)));
        tbl.push_back(r("txdone",     0, 12'o7000, F0, 12'o0000, 0, 8'h00, 0, 1, e(0, 8'hAA, 12'o0000, 0, 0, 0, 0)));
        tbl.push_back(r("txdone_irq", 0, 12'o7000, F0, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'hAA, 12'o0000, 0, 0, 1, 0)));
        tbl.push_back(r("rx55",       0, 12'o7000, F0, 12'o0000, 1, 8'h55, 0, 0, e(0, 8'hAA, 12'o0000, 0, 0, 1, 0)));
        tbl.push_back(r("krb_f1",     0, 12'o6036, F1, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'hAA, 12'o0125, 1, 0, 1, 0)));
        tbl.push_back(r("krb_f2",     0, 12'o6036, F2, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'hAA, 12'o0125, 1, 0, 1, 0)));
        tbl.push_back(r("krb_f0",     0, 12'o7000, F0, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'hAA, 12'o0000, 0, 0, 1, 0)));
        tbl.push_back(r("tcf_f1",     0, 12'o6042, F1, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'hAA, 12'o0000, 0, 0, 1, 0)));
        tbl.push_back(r("tcf_f2",     0, 12'o6042, F2, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'hAA, 12'o0000, 0, 0, 0, 0)));
        tbl.push_back(r("rx11",       0, 12'o7000, F0, 12'o0000, 1, 8'h11, 0, 0, e(0, 8'hAA, 12'o0000, 0, 0, 0, 0)));
        tbl.push_back(r("rx22_ovr",   0, 12'o7000, F0, 12'o0000, 1, 8'h22, 0, 0, e(0, 8'hAA, 12'o0000, 0, 0, 1, 1)));
        tbl.push_back(r("krs_f1",     0, 12'o6034, F1, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'hAA, 12'o0042, 0, 0, 1, 1)));
        tbl.push_back(r("krs_f0",     0, 12'o7000, F0, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'hAA, 12'o0000, 0, 0, 1, 1)));
        tbl.push_back(r("ksf_f1",     0, 12'o6031, F1, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'hAA, 12'o0000, 0, 1, 1, 1)));
        tbl.push_back(r("kcc_f1",     0, 12'o6032, F1, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'hAA, 12'o0000, 1, 0, 1, 0)));
        tbl.push_back(r("kcc_f2",     0, 12'o6032, F2, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'hAA, 12'o0000, 1, 0, 0, 0)));
        tbl.push_back(r("kcf_rx",     0, 12'o6030, F1, 12'o0000, 1, 8'h77, 0, 0, e(0, 8'hAA, 12'o0000, 0, 0, 0, 0)));
        tbl.push_back(r("kcf_rx_f2",  0, 12'o6030, F2, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'hAA, 12'o0000, 0, 0, 1, 0)));
        tbl.push_back(r("ksf2_f1",    0, 12'o6031, F1, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'hAA, 12'o0000, 0, 1, 1, 0)));
        tbl.push_back(r("krs2_f1",    0, 12'o6034, F1, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'hAA, 12'o0167, 0, 0, 1, 0)));
        tbl.push_back(r("tsk_f1",     0, 12'o6045, F1, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'hAA, 12'o0000, 0, 1, 1, 0)));
        tbl.push_back(r("clr_f0",     0, 12'o7000, F0, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'hAA, 12'o0000, 0, 0, 1, 0)));
        tbl.push_back(r("kcf_f3",     0, 12'o6030, F3, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'hAA, 12'o0000, 0, 0, 1, 0)));
        tbl.push_back(r("dev05_f1",   0, 12'o6051, F1, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'hAA, 12'o0000, 0, 0, 1, 0)));
        tbl.push_back(r("ksf3_f1",    0, 12'o6031, F1, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'hAA, 12'o0000, 0, 1, 1, 0)));
        tbl.push_back(r("tcf_done",   0, 12'o6042, F1, 12'o0000, 0, 8'h00, 0, 1, e(0, 8'hAA, 12'o0000, 0, 0, 1, 0)));
        tbl.push_back(r("tsf2_f1",    0, 12'o6041, F1, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'hAA, 12'o0000, 0, 1, 1, 0)));
        tbl.push_back(r("clr2_f0",    0, 12'o7000, F0, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'hAA, 12'o0000, 0, 0, 1, 0)));
        tbl.push_back(r("kie_f2",     0, 12'o6035, F2, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'hAA, 12'o0000, 0, 0, 1, 0)));
        tbl.push_back(r("kie_f0",     0, 12'o6035, F0, 12'o0000, 0, 8'h00, 0, 0, e(0, 8'hAA, 12'o0000, 0, 0, 1, 0)));

        foreach (tbl[i]) begin
            drive(tbl[i]);
            check(tbl[i].name, outs(), tbl[i].exp);
        end

        // Two requests while the UART is busy: nothing leaves until busy falls, then only the last byte.
        hs(0, 12'o6044, F1, 12'o0101, 1); check("pend_a_ld", {24'b0, tx_load}, 25'd0);
        hs(0, 12'o6044, F2, 12'o0101, 1); check("pend_b_ld", {24'b0, tx_load}, 25'd0);
        hs(0, 12'o6044, F1, 12'o0102, 1); check("pend_c_ld", {24'b0, tx_load}, 25'd0);
        for (int k = 0; k < 3; k++) begin
            hs(0, 12'o7000, F0, 12'o0000, 1);
            check("pend_busy_ld", {24'b0, tx_load}, 25'd0);
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            hs(0, 12'o7000, F0, 12'o0000, 0);
            n++;
            got = tx_load;
        end
        check("pend_latency", 25'(n), 25'd1);
        check("pend_byte", {17'b0, tx_data}, 25'h42);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            hs(0, 12'o7000, F0, 12'o0000, 0);
            cnt += int'(tx_load);
        end
        check("pend_single", 25'(cnt), 25'd0);

        // A request during SEND is parked and issued once the UART is free.
        hs(0, 12'o6044, F1, 12'o0110, 0); check("send_ld", {16'b0, tx_load, tx_data}, {16'b0, 1'b1, 8'h48});
        hs(0, 12'o6044, F1, 12'o0111, 0); check("send_req_ld", {24'b0, tx_load}, 25'd0);
        hs(0, 12'o7000, F0, 12'o0000, 0); check("send_wait_ld", {16'b0, tx_load, tx_data}, {16'b0, 1'b1, 8'h49});
        hs(0, 12'o7000, F0, 12'o0000, 0); check("send_gap_ld", {24'b0, tx_load}, 25'd0);

        // Reset while a byte is parked discards it.
        hs(0, 12'o6044, F1, 12'o0101, 1); check("rstw_ld", {24'b0, tx_load}, 25'd0);
        hs(1, 12'o7000, F0, 12'o0000, 1); check("rstw_outs", outs(), 25'd0);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            hs(0, 12'o7000, F0, 12'o0000, 0);
            cnt += int'(tx_load);
        end
        check("rstw_no_ld", 25'(cnt), 25'd0);
        check("rstw_irq", {24'b0, interrupt}, 25'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
